// File: rtl/dma_pkg.sv
// Shared DMA definitions: controller state encoding and default geometry.
package dma_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StXfer,
      StDone
   } dma_state_e;

   localparam int unsigned DmaWordSize = 16;
   localparam int unsigned DmaBurstLen = 4;

endpackage

// File: rtl/dma_beat_counter.sv
// Beat bookkeeping: total words moved plus beats within the current bus tenure.
module dma_beat_counter
   import dma_pkg::*;
#(
   parameter int unsigned LEN_W     = 4,
   parameter int unsigned BURST_LEN = DmaBurstLen
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             beat_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [LEN_W-1:0] count_o,
   output logic             burst_end_o,
   output logic             last_beat_o
);

   localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   logic [LEN_W-1:0]  count_q, count_d;
   logic [BurstW-1:0] burst_q, burst_d;

   assign count_o     = count_q;
   // Flags describe the beat that would happen this cycle.
   assign burst_end_o = (burst_q == BurstW'(BURST_LEN - 1));
   assign last_beat_o = (({1'b0, count_q} + (LEN_W + 1)'(1)) == {1'b0, len_i});

   // Next count: cleared on command accept, bumped on every beat.
   always_comb begin
      count_d = count_q;
      burst_d = burst_q;
      if (clear_i) begin
         count_d = '0;
         burst_d = '0;
      end else if (beat_i) begin
         count_d = count_q + LEN_W'(1);
         burst_d = burst_end_o ? '0 : burst_q + BurstW'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         burst_q <= '0;
      end else begin
         count_q <= count_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/dma_controller.sv
// Device-to-memory DMA engine with bus request/grant and bounded bursts.
// Optional abort support is enabled by defining DMA_ABORT_EN.
module dma_controller
   import dma_pkg::*;
#(
   parameter int unsigned WORD_SIZE = DmaWordSize,
   parameter int unsigned BURST_LEN = DmaBurstLen,
   parameter int unsigned LEN_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [WORD_SIZE-1:0] cmd_addr,
   input  logic [LEN_W-1:0]     cmd_len,
   output logic                 bus_req,
   input  logic                 bus_grant,
   input  logic [WORD_SIZE-1:0] dev_data,
   input  logic                 dev_valid,
   output logic                 dev_ready,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_data,
   output logic                 mem_write,
   output logic                 dma_done,
`ifdef DMA_ABORT_EN
   input  logic                 abort,
   output logic                 aborted,
`endif
   output logic                 busy
);

   dma_state_e state_q, state_d;

   logic [WORD_SIZE-1:0] base_q;
   logic [LEN_W-1:0]     len_q;
   logic                 gap_q, gap_d;
   logic [WORD_SIZE-1:0] mem_addr_q, mem_data_q;

   logic             accept;
   logic             beat;
   logic             abort_w;
   logic [LEN_W-1:0] count;
   logic             burst_end;
   logic             last_beat;

   assign accept    = cmd_valid & cmd_ready;
   assign dev_ready = (state_q == StXfer) & bus_grant & ~abort_w;
   assign beat      = dev_valid & dev_ready;
   assign busy      = (state_q != StIdle);

   dma_beat_counter #(
      .LEN_W     (LEN_W),
      .BURST_LEN (BURST_LEN)
   ) u_beat_counter (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (accept),
      .beat_i      (beat),
      .len_i       (len_q),
      .count_o     (count),
      .burst_end_o (burst_end),
      .last_beat_o (last_beat)
   );

   // Write port: live on a beat, otherwise hold the last written values.
   always_comb begin
      mem_write   = beat;
      mem_address = mem_addr_q;
      mem_data    = mem_data_q;
      if (beat) begin
         mem_address = base_q + WORD_SIZE'(count);
         mem_data    = dev_data;
      end
   end

   // Next-state and handshake outputs; gap_q marks the one-cycle release between bursts.
   always_comb begin
      state_d   = state_q;
      gap_d     = 1'b0;
      cmd_ready = 1'b0;
      bus_req   = 1'b0;
      dma_done  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = (cmd_len == '0) ? StDone : StReq;
            end
         end
         StReq: begin
            bus_req = ~gap_q;
            if (abort_w) begin
               state_d = StDone;
            end else if (!gap_q && bus_grant) begin
               state_d = StXfer;
            end
         end
         StXfer: begin
            bus_req = 1'b1;
            if (abort_w) begin
               state_d = StDone;
            end else if (beat) begin
               if (last_beat) begin
                  state_d = StDone;
               end else if (burst_end) begin
                  state_d = StReq;
                  gap_d   = 1'b1;
               end
            end
         end
         StDone: begin
            dma_done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, command latch and write-port hold registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         gap_q      <= 1'b0;
         base_q     <= '0;
         len_q      <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         if (accept) begin
            base_q <= cmd_addr;
            len_q  <= cmd_len;
         end
         if (beat) begin
            mem_addr_q <= mem_address;
            mem_data_q <= dev_data;
         end
      end
   end

`ifdef DMA_ABORT_EN
   logic aborted_q;

   assign abort_w = abort & ((state_q == StReq) | (state_q == StXfer));
   assign aborted = aborted_q;

   // Sticky abort flag, cleared by the next accepted command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aborted_q <= 1'b0;
      end else if (accept) begin
         aborted_q <= 1'b0;
      end else if (abort_w) begin
         aborted_q <= 1'b1;
      end
   end
`else
   assign abort_w = 1'b0;
`endif

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: directed scenarios plus randomized transfers,
// compared against a word-list scoreboard derived from base address and length.
module tb_dma_controller;

   localparam int unsigned WS = 16;
   localparam int unsigned BL = 4;
   localparam int unsigned LW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [WS-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          bus_req;
   logic          bus_grant = 1'b0;
   logic [WS-1:0] dev_data = '0;
   logic          dev_valid = 1'b0;
   logic          dev_ready;
   logic [WS-1:0] mem_address;
   logic [WS-1:0] mem_data;
   logic          mem_write;
   logic          dma_done;
   logic          busy;
`ifdef DMA_ABORT_EN
   logic          abort = 1'b0;
   logic          aborted;
`endif

   always #5 clk = ~clk;

   dma_controller #(
      .WORD_SIZE (WS),
      .BURST_LEN (BL),
      .LEN_W     (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .bus_req     (bus_req),
      .bus_grant   (bus_grant),
      .dev_data    (dev_data),
      .dev_valid   (dev_valid),
      .dev_ready   (dev_ready),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_write   (mem_write),
      .dma_done    (dma_done),
`ifdef DMA_ABORT_EN
      .abort       (abort),
      .aborted     (aborted),
`endif
      .busy        (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Stimulus controls applied at the start of each cycle.
   logic cv_n = 1'b0;
   logic ab_n = 1'b0;
   logic req_prev = 1'b0;
   int   hold_cnt = 0;
   bit   vrand = 1'b0;

   // Scoreboard and monitor state for one transfer.
   logic [WS-1:0] words[$];
   logic [WS-1:0] cap_addr[$];
   logic [WS-1:0] cap_data[$];
   int ptr, bad_grant, bad_hs, n_done, done_cyc, last_wr_cyc, req_ones;
   int seg, max_seg, gaps, low_run, bad_gap_len, stray;
   bit seen_req;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_monitor();
      cap_addr.delete();
      cap_data.delete();
      ptr = 0; bad_grant = 0; bad_hs = 0; n_done = 0; done_cyc = -1; last_wr_cyc = -1;
      req_ones = 0; seg = 0; max_seg = 0; gaps = 0; low_run = 0; bad_gap_len = 0; stray = 0;
      seen_req = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe settled outputs.
   task automatic step();
      @(negedge clk);
      cmd_valid = cv_n;
`ifdef DMA_ABORT_EN
      abort = ab_n;
`endif
      ab_n = 1'b0;
      if (hold_cnt > 0) begin
         bus_grant = 1'b0;
         hold_cnt--;
      end else begin
         bus_grant = req_prev;
      end
      dev_valid = vrand ? ($urandom_range(3) != 0) : 1'b1;
      dev_data  = (ptr < words.size()) ? words[ptr] : WS'($urandom);
      #1;
      cyc++;
      if (mem_write) begin
         cap_addr.push_back(mem_address);
         cap_data.push_back(mem_data);
         last_wr_cyc = cyc;
         if (!bus_grant) bad_grant++;
         seg++;
         if (seg > max_seg) max_seg = seg;
      end
      if (mem_write !== (dev_valid & dev_ready)) bad_hs++;
      if (dev_valid && dev_ready) ptr++;
      if (dma_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (cmd_valid && cmd_ready && busy) stray++;
      if (bus_req) begin
         if (seen_req && low_run > 0) begin
            gaps++;
            if (low_run != 1) bad_gap_len++;
         end
         low_run  = 0;
         seen_req = 1'b1;
         req_ones++;
      end else begin
         seg = 0;
         if (seen_req) low_run++;
      end
      req_prev = bus_req;
   endtask

   // mode 0: run to completion; mode 1: reset after 5th write; mode 2: abort after 5th write.
   task automatic run_xfer(input logic [WS-1:0] addr, input logic [LW-1:0] len,
                           input int hold_after, input bit vr, input int mode, input string tag);
      int  acc_cyc;
      int  exp_wr;
      int  exp_gaps;
      bit  held;
      bit  fin;
      clear_monitor();
      words.delete();
      for (int i = 0; i < int'(len); i++) words.push_back(WS'($urandom));
      vrand    = vr;
      held     = 1'b0;
      fin      = 1'b0;
      cmd_addr = addr;
      cmd_len  = len;
      cv_n     = 1'b1;
      step();
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      acc_cyc = cyc;
      cv_n    = 1'b0;
      for (int k = 0; k < 300 && !fin; k++) begin
         // Stray commands early in a long transfer must be ignored.
         cv_n = (mode == 0) && (len > LW'(4)) && (k >= 1) && (k <= 3);
         step();
         cv_n = 1'b0;
         if (hold_after > 0 && !held && cap_addr.size() == hold_after) begin
            hold_cnt = 3;
            held     = 1'b1;
         end
         if (mode == 2 && cap_addr.size() == 5 && !held) begin
            ab_n = 1'b1;
            held = 1'b1;
         end
         if (mode == 1 && cap_addr.size() == 5) begin
            reset = 1'b1;
            #1;
            check({tag, "_rst_bus_req"}, bus_req, 0);
            check({tag, "_rst_mem_write"}, mem_write, 0);
            check({tag, "_rst_dev_ready"}, dev_ready, 0);
            check({tag, "_rst_done"}, dma_done, 0);
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_addr"}, mem_address, 0);
            check({tag, "_rst_data"}, mem_data, 0);
            @(negedge clk);
            reset    = 1'b0;
            req_prev = 1'b0;
            hold_cnt = 0;
            #1;
            check({tag, "_rst_cmd_ready"}, cmd_ready, 1);
            fin = 1'b1;
         end
         if (dma_done) fin = 1'b1;
      end
      check({tag, "_finished"}, fin, 1);
      exp_wr = (mode == 0) ? int'(len) : 5;
      check({tag, "_n_writes"}, cap_addr.size(), exp_wr);
      for (int i = 0; i < exp_wr && i < cap_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), cap_addr[i], WS'(addr + WS'(i)));
         check($sformatf("%s_data%0d", tag, i), cap_data[i], words[i]);
      end
      check({tag, "_write_wo_grant"}, bad_grant, 0);
      check({tag, "_write_vs_handshake"}, bad_hs, 0);
      if (mode == 1) return;
      check({tag, "_n_done"}, n_done, 1);
      check({tag, "_stray_accept"}, stray, 0);
      if (mode == 0) begin
         exp_gaps = (len == '0) ? 0 : (int'(len) + BL - 1) / BL - 1;
         check({tag, "_done_cycle"}, done_cyc, (len == '0) ? acc_cyc + 1 : last_wr_cyc + 1);
      end else begin
         exp_gaps = 1;
         check({tag, "_done_cycle"}, done_cyc, last_wr_cyc + 2);
      end
      check({tag, "_gaps"}, gaps, exp_gaps);
      check({tag, "_gap_len"}, bad_gap_len, 0);
      check({tag, "_burst_max"}, max_seg <= BL, 1);
      if (len == '0) check({tag, "_no_req"}, req_ones, 0);
      step();
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_req"}, bus_req, 0);
      check({tag, "_idle_done"}, dma_done, 0);
      check({tag, "_idle_ready"}, cmd_ready, 1);
      check({tag, "_idle_write"}, mem_write, 0);
`ifdef DMA_ABORT_EN
      check({tag, "_aborted"}, aborted, (mode == 2) ? 1 : 0);
`endif
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("reset_bus_req", bus_req, 0);
      check("reset_mem_write", mem_write, 0);
      check("reset_dev_ready", dev_ready, 0);
      check("reset_done", dma_done, 0);
      check("reset_busy", busy, 0);
      check("reset_addr", mem_address, 0);
      check("reset_data", mem_data, 0);
      check("reset_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_xfer(16'h0100, 4'd12, 0, 1'b0, 0, "three_bursts");
      run_xfer(16'h0040, 4'd0, 0, 1'b0, 0, "len_zero");
      run_xfer(16'hFFFE, 4'd4, 0, 1'b0, 0, "wrap");
      run_xfer(16'h0200, 4'd6, 2, 1'b0, 0, "grant_gap");
      run_xfer(16'h0300, 4'd12, 0, 1'b0, 1, "reset_mid");
      run_xfer(16'h0400, 4'd7, 0, 1'b0, 0, "after_reset");
      for (int r = 0; r < 6; r++) begin
         logic [LW-1:0] rl;
         int            rh;
         rl = LW'($urandom_range(15, 1));
         rh = $urandom_range(3);
         if (rh >= int'(rl)) rh = 0;
         run_xfer(WS'($urandom), rl, rh, 1'b1, 0, $sformatf("rand%0d", r));
      end
`ifdef DMA_ABORT_EN
      run_xfer(16'h0500, 4'd12, 0, 1'b0, 2, "abort");
      run_xfer(16'h0600, 4'd3, 0, 1'b0, 0, "after_abort");
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of the address and data words.
REQ-002 Parameter BURST_LEN, default 4: maximum number of words per bus tenure.
REQ-003 Parameter LEN_W, default 4: width of the transfer-length field.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports cmd_valid (input, 1) / cmd_ready (output, 1): command handshake from the CPU.
REQ-007 Ports cmd_addr (input, WORD_SIZE) / cmd_len (input, LEN_W): start address and word count.
REQ-008 Port bus_req, output, 1: data-memory bus request to the CPU.
REQ-009 Port bus_grant, input, 1: bus grant from the CPU.
REQ-010 Ports dev_data (input, WORD_SIZE), dev_valid (input, 1), dev_ready (output, 1): device source stream.
REQ-011 Ports mem_address (output, WORD_SIZE), mem_data (output, WORD_SIZE), mem_write (output, 1): data-memory write port.
REQ-012 Ports dma_done (output, 1) and busy (output, 1): completion pulse and activity flag.

Function
REQ-013 FSM states: IDLE, REQ, XFER, DONE.
REQ-014 cmd_ready = 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, latching base address, length, and count = 0.
REQ-015 On command accept: cmd_len = 0 goes to DONE; cmd_len ≠ 0 goes to REQ.
REQ-016 bus_req = 1 in REQ and XFER; REQ -> XFER when bus_grant = 1.
REQ-017 dev_ready = (state == XFER) & bus_grant; a beat occurs when dev_valid & dev_ready.
REQ-018 On a beat, in the same cycle: mem_write = 1, mem_address = base + count (mod 2^WORD_SIZE, wraps), mem_data = dev_data; count increments at the next edge.
REQ-019 No beat means mem_write = 0; mem_address/mem_data hold their last values and are don't-care.
REQ-020 Beat-to-beat throughput SHALL be one word per cycle; zero-cycle combinational latency from dev_data to mem_data.
REQ-021 Burst end (BURST_LEN beats in the tenure) with words remaining: deassert bus_req for exactly one cycle (state REQ, bus_req forced 0), then re-request.
REQ-022 Last beat (count + 1 == length): XFER -> DONE, and bus_req drops the next cycle.
REQ-023 bus_grant falling during XFER pauses the transfer (no beats) without losing count; the transfer resumes when the grant returns.
REQ-024 DONE lasts one cycle, dma_done = 1 for that cycle only, then IDLE.
REQ-025 busy = (state ≠ IDLE).
REQ-026 cmd_valid outside IDLE is ignored and not queued.

Reset
REQ-027 Reset asserted at any time (including mid-burst) forces IDLE, count = 0, and bus_req, mem_write, dev_ready, dma_done, busy = 0.
REQ-028 Reset forces mem_address and mem_data to 0; cmd_ready = 1 after reset.

Configuration
REQ-029 Macro DMA_ABORT_EN: when defined, input port abort (1) exists; abort = 1 in REQ or XFER blocks any beat that cycle and moves to DONE (bus_req 0 next cycle, dma_done pulses), and output aborted (1) is set until the next command accept.
REQ-030 Without DMA_ABORT_EN: no abort or aborted ports; a transfer always runs to completion.

Structure
REQ-031 Shared package dma_pkg holds the state enum, the WORD_SIZE default, and the BURST_LEN default.
REQ-032 Sub-module dma_beat_counter holds the total count and the in-burst count, with burst-end and last-beat flags.

Verification
REQ-033 addr = 0x0100, len = 12, grant follows request next cycle, dev_valid always 1 -> three 4-word bursts at 0x0100–0x010B; bus_req low one cycle between bursts; single dma_done.
REQ-034 len = 0 -> dma_done the cycle after accept; bus_req and mem_write never asserted.
REQ-035 addr = 0xFFFE, len = 4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 bus_grant dropped for 3 cycles after the 2nd beat -> no mem_write during the gap; the 3rd beat goes to base + 2.
REQ-037 reset pulse after the 5th beat of len = 12 -> all outputs 0 immediately, cmd_ready = 1 after release, new command accepted normally.
REQ-038 (DMA_ABORT_EN) abort during the 2nd burst -> no further writes, dma_done = 1, aborted = 1.
